pc_trap_unit: RTL and testbench

Parametrised next-generation program counter for the RISC-V core front end. It keeps the fetch address, increments it when the fetch unit is ready, and applies jumps and conditional branches from execute. It adds trap handling beyond the legacy PC: misaligned-target and external-fault traps, a saved exception PC with cause and trap value, trap return, and a halt state on double fault.

---
 rtl/pc_trap_unit.sv | 156 +++++++++++++++
 tb/tb_pc_trap_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_trap_unit.sv
// Fetch program counter with jump/branch redirect, trap entry/return and
// double-fault halt. All outputs are registered; inputs only steer next state.
module pc_trap_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] TRAP_VECTOR  = {XLEN{1'b0}},
  parameter int unsigned     IALIGN       = 32,
  parameter int unsigned     STEP         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [1:0]      jmp_op,
  input  logic [XLEN-1:0] target,
  input  logic            cmp,
  input  logic            fault_in,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] epc,
  output logic [1:0]      cause,
  output logic [XLEN-1:0] tval,
  output logic            in_trap,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [1:0] OP_JMP    = 2'd1;
  localparam logic [1:0] OP_BRANCH = 2'd2;
  localparam logic [1:0] OP_TRET   = 2'd3;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_ALIGN = 2'd1;
  localparam logic [1:0] CAUSE_FAULT = 2'd2;
  localparam logic [1:0] CAUSE_TRET  = 2'd3;

  localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);
  localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};

  state_t          state_r;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] epc_r;
  logic [1:0]      cause_r;
  logic [XLEN-1:0] tval_r;
  logic            in_trap_r;
  logic            halted_r;

  logic            misaligned_s;
  logic            take_s;
  logic            tret_s;
  logic            trap_s;
  logic [1:0]      trap_cause_s;
  logic [XLEN-1:0] trap_tval_s;

  // Redirect decode and trap prioritisation (fault > misaligned > illegal TRET).
  always_comb begin
    misaligned_s = 1'b0;
    trap_s       = 1'b0;
    trap_cause_s = CAUSE_NONE;
    trap_tval_s  = ZERO_W;

    if (IALIGN == 32'd16) begin
      misaligned_s = target[0];
    end else begin
      misaligned_s = |target[1:0];
    end

    take_s = redirect_valid &&
             ((jmp_op == OP_JMP) || ((jmp_op == OP_BRANCH) && cmp));
    tret_s = redirect_valid && (jmp_op == OP_TRET);

    if (redirect_valid && fault_in) begin
      trap_s       = 1'b1;
      trap_cause_s = CAUSE_FAULT;
      trap_tval_s  = ZERO_W;
    end else if (take_s && misaligned_s) begin
      trap_s       = 1'b1;
      trap_cause_s = CAUSE_ALIGN;
      trap_tval_s  = target;
    end else if (tret_s && (state_r == ST_RUN)) begin
      trap_s       = 1'b1;
      trap_cause_s = CAUSE_TRET;
      trap_tval_s  = ZERO_W;
    end else begin
      trap_s       = 1'b0;
      trap_cause_s = CAUSE_NONE;
      trap_tval_s  = ZERO_W;
    end
  end

  // PC state machine with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      addr_r    <= RESET_VECTOR;
      epc_r     <= ZERO_W;
      cause_r   <= CAUSE_NONE;
      tval_r    <= ZERO_W;
      in_trap_r <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN, ST_TRAP: begin
          if (trap_s) begin
            if (state_r == ST_TRAP) begin
              // Double fault: freeze everything for post-mortem inspection.
              state_r   <= ST_HALT;
              in_trap_r <= 1'b0;
              halted_r  <= 1'b1;
            end else begin
              state_r   <= ST_TRAP;
              epc_r     <= addr_r;
              addr_r    <= TRAP_VECTOR;
              cause_r   <= trap_cause_s;
              tval_r    <= trap_tval_s;
              in_trap_r <= 1'b1;
              halted_r  <= 1'b0;
            end
          end else if (take_s) begin
            addr_r <= target;
          end else if (tret_s && (state_r == ST_TRAP)) begin
            state_r   <= ST_RUN;
            addr_r    <= epc_r;
            in_trap_r <= 1'b0;
          end else if (fetch_ready) begin
            addr_r <= addr_r + STEP_W;
          end else begin
            addr_r <= addr_r;
          end
        end
        ST_HALT: begin
          state_r   <= ST_HALT;
          in_trap_r <= 1'b0;
          halted_r  <= 1'b1;
        end
        default: begin
          state_r   <= ST_HALT;
          in_trap_r <= 1'b0;
          halted_r  <= 1'b1;
        end
      endcase
    end
  end

  assign addr    = addr_r;
  assign epc     = epc_r;
  assign cause   = cause_r;
  assign tval    = tval_r;
  assign in_trap = in_trap_r;
  assign halted  = halted_r;

endmodule

// File: tb/tb_pc_trap_unit.sv
// Directed bench for pc_trap_unit: word-aligned, halfword-aligned and 8-bit
// instances, each checked against hand-computed expectations.
module tb_pc_trap_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Shared stimulus for instances a (IALIGN=32) and b (IALIGN=16)
  logic        rst_n = 1'b0;
  logic        fetch_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  jmp_op = 2'd0;
  logic [31:0] target = 32'd0;
  logic        cmp = 1'b0;
  logic        fault_in = 1'b0;

  logic [31:0] a_addr, a_epc, a_tval, b_addr, b_epc, b_tval;
  logic [1:0]  a_cause, b_cause;
  logic        a_in_trap, a_halted, b_in_trap, b_halted;

  // Stimulus for the 8-bit instance c
  logic       c_rst_n = 1'b0;
  logic       c_fetch_ready = 1'b0;
  logic       c_redirect_valid = 1'b0;
  logic [1:0] c_jmp_op = 2'd0;
  logic [7:0] c_target = 8'd0;
  logic       c_cmp = 1'b0;
  logic       c_fault_in = 1'b0;
  logic [7:0] c_addr, c_epc, c_tval;
  logic [1:0] c_cause;
  logic       c_in_trap, c_halted;

  pc_trap_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
                 .IALIGN(32), .STEP(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .jmp_op(jmp_op), .target(target),
    .cmp(cmp), .fault_in(fault_in), .addr(a_addr), .epc(a_epc),
    .cause(a_cause), .tval(a_tval), .in_trap(a_in_trap), .halted(a_halted));

  pc_trap_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
                 .IALIGN(16), .STEP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .jmp_op(jmp_op), .target(target),
    .cmp(cmp), .fault_in(fault_in), .addr(b_addr), .epc(b_epc),
    .cause(b_cause), .tval(b_tval), .in_trap(b_in_trap), .halted(b_halted));

  pc_trap_unit #(.XLEN(8), .RESET_VECTOR(8'h0), .TRAP_VECTOR(8'h0),
                 .IALIGN(32), .STEP(4)) dut_c (
    .clk(clk), .rst_n(c_rst_n), .fetch_ready(c_fetch_ready),
    .redirect_valid(c_redirect_valid), .jmp_op(c_jmp_op), .target(c_target),
    .cmp(c_cmp), .fault_in(c_fault_in), .addr(c_addr), .epc(c_epc),
    .cause(c_cause), .tval(c_tval), .in_trap(c_in_trap), .halted(c_halted));

  // Drive one cycle of shared stimulus at negedge, return 1 time unit after the posedge
  task automatic step(input logic fr, input logic rv, input logic [1:0] op,
                      input logic [31:0] tg, input logic c, input logic f);
    @(negedge clk);
    fetch_ready = fr; redirect_valid = rv; jmp_op = op;
    target = tg; cmp = c; fault_in = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    c_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (a_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want %h", a_addr, 32'h0); end
    tests_run++; if ({a_epc, a_tval} !== 64'h0) begin tests_failed++; $display("FAIL reset_epc_tval: got %h %h want 0 0", a_epc, a_tval); end
    tests_run++; if ({a_cause, a_in_trap, a_halted} !== 4'b0000) begin tests_failed++; $display("FAIL reset_status: got cause=%0d in_trap=%b halted=%b want 0 0 0", a_cause, a_in_trap, a_halted); end
    @(negedge clk);
    rst_n = 1'b1;
    c_rst_n = 1'b1;
  endtask

  task automatic test_fetch;
    logic [31:0] exp_addr;
    exp_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
      exp_addr = exp_addr + 32'd4;
      tests_run++; if (a_addr !== exp_addr) begin tests_failed++; $display("FAIL fetch_inc%0d: got %h want %h", i, a_addr, exp_addr); end
    end
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    tests_run++; if (a_addr !== 32'hC) begin tests_failed++; $display("FAIL fetch_hold: got %h want %h", a_addr, 32'hC); end
    // jmp_op NONE with redirect_valid acts as plain fetch
    step(1'b1, 1'b1, 2'd0, 32'h44, 1'b1, 1'b0);
    tests_run++; if (a_addr !== 32'h10) begin tests_failed++; $display("FAIL op_none: got %h want %h", a_addr, 32'h10); end
  endtask

  task automatic test_jump_branch;
    step(1'b0, 1'b1, 2'd1, 32'h40, 1'b0, 1'b0);
    tests_run++; if (a_addr !== 32'h40) begin tests_failed++; $display("FAIL jmp_stalled: got %h want %h", a_addr, 32'h40); end
    step(1'b0, 1'b1, 2'd2, 32'h80, 1'b0, 1'b0);
    tests_run++; if (a_addr !== 32'h40) begin tests_failed++; $display("FAIL branch_untaken: got %h want %h", a_addr, 32'h40); end
    step(1'b0, 1'b1, 2'd2, 32'h80, 1'b1, 1'b0);
    tests_run++; if (a_addr !== 32'h80) begin tests_failed++; $display("FAIL branch_taken: got %h want %h", a_addr, 32'h80); end
    step(1'b0, 1'b1, 2'd2, 32'h83, 1'b0, 1'b0);
    tests_run++; if ({a_addr, a_in_trap} !== {32'h80, 1'b0}) begin tests_failed++; $display("FAIL untaken_misaligned: got %h trap=%b want %h trap=0", a_addr, a_in_trap, 32'h80); end
  endtask

  task automatic test_misaligned_trap;
    step(1'b0, 1'b1, 2'd2, 32'h82, 1'b1, 1'b0);
    tests_run++; if (a_addr !== 32'h100) begin tests_failed++; $display("FAIL mis_addr: got %h want %h", a_addr, 32'h100); end
    tests_run++; if (a_epc !== 32'h80) begin tests_failed++; $display("FAIL mis_epc: got %h want %h", a_epc, 32'h80); end
    tests_run++; if ({a_cause, a_tval} !== {2'd1, 32'h82}) begin tests_failed++; $display("FAIL mis_cause_tval: got %0d %h want 1 %h", a_cause, a_tval, 32'h82); end
    tests_run++; if ({a_in_trap, a_halted} !== 2'b10) begin tests_failed++; $display("FAIL mis_in_trap: got in_trap=%b halted=%b want 1 0", a_in_trap, a_halted); end
    tests_run++; if ({b_addr, b_in_trap} !== {32'h82, 1'b0}) begin tests_failed++; $display("FAIL ialign16_no_trap: got %h trap=%b want %h trap=0", b_addr, b_in_trap, 32'h82); end
  endtask

  task automatic test_tret;
    step(1'b0, 1'b1, 2'd3, 32'h0, 1'b0, 1'b0);
    tests_run++; if ({a_addr, a_in_trap} !== {32'h80, 1'b0}) begin tests_failed++; $display("FAIL tret_return: got %h trap=%b want %h trap=0", a_addr, a_in_trap, 32'h80); end
    tests_run++; if ({a_cause, a_tval} !== {2'd1, 32'h82}) begin tests_failed++; $display("FAIL tret_keeps_cause: got %0d %h want 1 %h", a_cause, a_tval, 32'h82); end
    // Instance b is in RUN, so the same TRET is illegal for it
    tests_run++; if ({b_addr, b_epc, b_cause, b_in_trap} !== {32'h100, 32'h82, 2'd3, 1'b1}) begin tests_failed++; $display("FAIL b_illegal_tret: got %h %h %0d %b want %h %h 3 1", b_addr, b_epc, b_cause, b_in_trap, 32'h100, 32'h82); end
  endtask

  task automatic test_tret_in_run;
    step(1'b0, 1'b1, 2'd1, 32'h10, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 32'h0, 1'b0, 1'b0);
    tests_run++; if ({a_addr, a_epc} !== {32'h100, 32'h10}) begin tests_failed++; $display("FAIL run_tret_addr_epc: got %h %h want %h %h", a_addr, a_epc, 32'h100, 32'h10); end
    tests_run++; if ({a_cause, a_tval, a_in_trap} !== {2'd3, 32'h0, 1'b1}) begin tests_failed++; $display("FAIL run_tret_cause: got %0d %h %b want 3 0 1", a_cause, a_tval, a_in_trap); end
  endtask

  task automatic test_double_fault;
    step(1'b1, 1'b1, 2'd0, 32'h0, 1'b0, 1'b1);
    tests_run++; if ({a_halted, a_in_trap} !== 2'b10) begin tests_failed++; $display("FAIL df_halt: got halted=%b in_trap=%b want 1 0", a_halted, a_in_trap); end
    tests_run++; if ({a_addr, a_epc, a_cause, a_tval} !== {32'h100, 32'h10, 2'd3, 32'h0}) begin tests_failed++; $display("FAIL df_frozen_state: got %h %h %0d %h want %h %h 3 0", a_addr, a_epc, a_cause, a_tval, 32'h100, 32'h10); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 2'd1, 32'h40, 1'b0, 1'b0);
      tests_run++; if ({a_addr, a_halted} !== {32'h100, 1'b1}) begin tests_failed++; $display("FAIL halt_freeze%0d: got %h halted=%b want %h 1", i, a_addr, a_halted, 32'h100); end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    fetch_ready = 1'b0; redirect_valid = 1'b0; jmp_op = 2'd0; fault_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if ({a_addr, a_halted, a_in_trap} !== {32'h0, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL async_reset: got %h halted=%b trap=%b want 0 0 0", a_addr, a_halted, a_in_trap); end
    tests_run++; if ({a_epc, a_cause} !== {32'h0, 2'd0}) begin tests_failed++; $display("FAIL async_reset_epc: got %h %0d want 0 0", a_epc, a_cause); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fault_priority;
    step(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 32'h3, 1'b0, 1'b1);
    tests_run++; if ({a_addr, a_epc} !== {32'h100, 32'h4}) begin tests_failed++; $display("FAIL fault_addr_epc: got %h %h want %h %h", a_addr, a_epc, 32'h100, 32'h4); end
    tests_run++; if ({a_cause, a_tval} !== {2'd2, 32'h0}) begin tests_failed++; $display("FAIL fault_priority: got %0d %h want 2 0", a_cause, a_tval); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    c_redirect_valid = 1'b1; c_jmp_op = 2'd1; c_target = 8'hFC; c_fetch_ready = 1'b0;
    @(posedge clk);
    #1;
    tests_run++; if (c_addr !== 8'hFC) begin tests_failed++; $display("FAIL wrap_setup: got %h want %h", c_addr, 8'hFC); end
    @(negedge clk);
    c_redirect_valid = 1'b0; c_jmp_op = 2'd0; c_fetch_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++; if ({c_addr, c_in_trap, c_cause} !== {8'h00, 1'b0, 2'd0}) begin tests_failed++; $display("FAIL wrap: got %h trap=%b cause=%0d want 00 0 0", c_addr, c_in_trap, c_cause); end
    @(negedge clk);
    c_fetch_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_jump_branch();
    test_misaligned_trap();
    test_tret();
    test_tret_in_run();
    test_double_fault();
    test_async_reset();
    test_fault_priority();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
